// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//
// Brings up the fabric PLL on the free-running board clock (refclk) and only
// releases the downstream reset once the PLL has reported a stable lock. The
// sequence is:
//   1. Hold the PLL in reset for a fixed number of cycles.
//   2. Wait for lock, with a timeout that triggers a retry.
//   3. Require a run of consecutive locked cycles.
//   4. Release sys_rst_n.
// Loss of lock while running, or a software request, restarts the sequence.
//
// Ports
//   refclk      in   sequencer clock, free running, independent of the PLL
//   rst_n       in   asynchronous active-low reset
//   pll_locked  in   PLL lock indication, asynchronous to refclk
//   sw_rst_req  in   single-cycle request to re-sequence the PLL
//   pll_rst     out  PLL reset, active high (asserted asynchronously by rst_n)
//   sys_rst_n   out  downstream reset, registered, 0 = hold in reset
//   pll_ready   out  high exactly while in RUN
//   pll_fail    out  sticky failure flag
//   loss_cnt    out  saturating count of lock losses seen in RUN
//   state_o     out  current state encoding, for debug
//
// Build option
//   PLL_RETRY_LIMIT_EN : when defined, MAX_RETRY consecutive lock timeouts
//                        park the sequencer in FAIL. When undefined, the
//                        sequencer retries forever, FAIL is unreachable,
//                        pll_fail is tied low and no retry counter exists.
//
// State | meaning
// ------+------------------------------------------------------------------
//   0   | PLL_RST   : PLL held in reset for RST_CYCLES cycles
//   1   | WAIT_LOCK : PLL released, waiting for synchronized lock (timeout)
//   2   | STABLE    : counting consecutive locked cycles
//   3   | RUN       : lock qualified, sys_rst_n released, pll_ready high
//   4   | FAIL      : retry budget exhausted, PLL held in reset
// -----------------------------------------------------------------------------
module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 4,
    parameter int CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             sw_rst_req,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             pll_ready,
    output logic             pll_fail,
    output logic [CNT_W-1:0] loss_cnt,
    output logic [2:0]       state_o
);

    // One shared cycle counter, sized for the longest of the three timers.
    localparam int MAX_AB = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
    localparam int MAX_C  = (MAX_AB > RST_CYCLES) ? MAX_AB : RST_CYCLES;
    localparam int TW     = $clog2(MAX_C + 1);

    localparam logic [TW-1:0] RST_LAST = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STB_LAST = TW'(STABLE_CYCLES - 1);

    if (RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1 || MAX_RETRY < 1 || CNT_W < 1)
    begin : g_bad_param
        $error("pll_reset_sequencer: cycle parameters, MAX_RETRY and CNT_W must be >= 1");
    end

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] cnt;
    logic [TW-1:0] cnt_nxt;
    logic          loss_inc;
    logic          sync_q1;
    logic          lk_s;
    logic          pll_rst_d;
    logic          run_d;

    // Two-flop synchronizer; the FSM looks only at lk_s.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            lk_s    <= 1'b0;
        end else begin
            sync_q1 <= pll_locked;
            lk_s    <= sync_q1;
        end
    end

`ifdef PLL_RETRY_LIMIT_EN
    localparam int RW = $clog2(MAX_RETRY + 1);

    logic [RW-1:0] retry_q;
    logic          retry_inc;
    logic          retry_clr;
    logic          retry_at_limit;
    logic          fail_d;

    // The timeout that is about to happen would be the MAX_RETRY-th in a row.
    assign retry_at_limit = (retry_q == RW'(MAX_RETRY - 1));

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            retry_q <= '0;
        end else if (retry_clr) begin
            retry_q <= '0;
        end else if (retry_inc) begin
            retry_q <= retry_q + 1'b1;
        end
    end
`endif

    // State register, shared cycle counter and lock-loss counter.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_PLL_RST;
            cnt      <= '0;
            loss_cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (loss_inc && (loss_cnt != {CNT_W{1'b1}})) begin
                loss_cnt <= loss_cnt + 1'b1;
            end
        end
    end

    // Next-state logic. A software request overrides everything, including
    // a lock loss in the same cycle, so that loss is not counted.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        loss_inc  = 1'b0;
`ifdef PLL_RETRY_LIMIT_EN
        retry_inc = 1'b0;
        retry_clr = 1'b0;
`endif
        if (sw_rst_req) begin
            state_nxt = S_PLL_RST;
            cnt_nxt   = '0;
`ifdef PLL_RETRY_LIMIT_EN
            retry_clr = 1'b1;
`endif
        end else begin
            case (state)
                S_PLL_RST: begin
                    if (cnt == RST_LAST) begin
                        state_nxt = S_WAIT_LOCK;
                        cnt_nxt   = '0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lk_s) begin
                        state_nxt = S_STABLE;
                        cnt_nxt   = '0;
                    end else if (cnt == TO_LAST) begin
                        cnt_nxt = '0;
`ifdef PLL_RETRY_LIMIT_EN
                        retry_inc = 1'b1;
                        state_nxt = retry_at_limit ? S_FAIL : S_PLL_RST;
`else
                        state_nxt = S_PLL_RST;
`endif
                    end
                end
                S_STABLE: begin
                    if (!lk_s) begin
                        // Glitch during qualification: fresh timeout, not a retry.
                        state_nxt = S_WAIT_LOCK;
                        cnt_nxt   = '0;
                    end else if (cnt == STB_LAST) begin
                        state_nxt = S_RUN;
                        cnt_nxt   = '0;
`ifdef PLL_RETRY_LIMIT_EN
                        retry_clr = 1'b1;
`endif
                    end
                end
                S_RUN: begin
                    cnt_nxt = '0;
                    if (!lk_s) begin
                        state_nxt = S_PLL_RST;
                        loss_inc  = 1'b1;
                    end
                end
                S_FAIL: begin
                    cnt_nxt = '0;
                end
                default: begin
                    state_nxt = S_PLL_RST;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they change
    // on the same edge as the state and never glitch on a state-bit decode.
    always_comb begin
        pll_rst_d = 1'b0;
        run_d     = 1'b0;
        case (state_nxt)
            S_PLL_RST: pll_rst_d = 1'b1;
            S_FAIL:    pll_rst_d = 1'b1;
            S_RUN:     run_d     = 1'b1;
            default:   ;
        endcase
`ifdef PLL_RETRY_LIMIT_EN
        fail_d = (state_nxt == S_FAIL);
`endif
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            pll_ready <= 1'b0;
        end else begin
            pll_rst   <= pll_rst_d;
            sys_rst_n <= run_d;
            pll_ready <= run_d;
        end
    end

`ifdef PLL_RETRY_LIMIT_EN
    // FAIL is left only through sw_rst_req or rst_n, which makes this sticky.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            pll_fail <= 1'b0;
        end else begin
            pll_fail <= fail_d;
        end
    end
`else
    assign pll_fail = 1'b0;
`endif

    assign state_o = state;

endmodule
